// File: rtl/expr_scanner.sv
// Streaming ASCII arithmetic-expression recogniser: one byte per in_valid edge, tracks operands, nesting, operators.
// Latency: one edge; outputs reflect all bytes accepted through the last edge. No backpressure: every valid byte is consumed.
module expr_scanner #(
    parameter int MAX_DIGITS  = 4,
    parameter int MAX_DEPTH   = 3,
    parameter int ALLOW_SPACE = 1,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             in_valid,
    input  logic [7:0]       in,
    output logic             out,
    output logic             err,
    output logic             done,
    output logic [2:0]       state,
    output logic [3:0]       depth,
    output logic [CNT_W-1:0] op_cnt
);

    typedef enum logic [2:0] {
        S_EXP   = 3'd0,
        S_NUM   = 3'd1,
        S_CLOSE = 3'd2,
        S_DONE  = 3'd3,
        S_ERR   = 3'd4
    } state_t;

    typedef enum logic [2:0] {
        C_DIGIT,
        C_OP,
        C_OPEN,
        C_CLOSE,
        C_EQ,
        C_SPACE,
        C_ILL
    } cls_t;

    localparam logic [3:0]       LP_MAX_DEPTH = 4'(MAX_DEPTH);
    localparam logic [3:0]       LP_MAX_DIG   = 4'(MAX_DIGITS);
    localparam logic [CNT_W-1:0] LP_OP_MAX    = '1;

    state_t           r_state;
    logic [3:0]       r_depth;
    logic [CNT_W-1:0] r_op_cnt;
    logic [3:0]       r_dig_cnt;
    logic             r_done;

    state_t           w_state_nxt;
    logic [3:0]       w_depth_nxt;
    logic [CNT_W-1:0] w_op_cnt_nxt;
    logic [3:0]       w_dig_cnt_nxt;
    logic             w_done_nxt;

    cls_t             w_cls;
    state_t           w_eff_state;
    logic [3:0]       w_base_depth;
    logic [CNT_W-1:0] w_base_op;
    logic [3:0]       w_base_dig;
    logic             w_fail;

    // Byte classifier
    always_comb begin
        w_cls = C_ILL;
        if (in >= 8'h30 && in <= 8'h39) begin
            w_cls = C_DIGIT;
        end else begin
            case (in)
                8'h2B, 8'h2D, 8'h2A, 8'h2F: w_cls = C_OP;
                8'h28:                      w_cls = C_OPEN;
                8'h29:                      w_cls = C_CLOSE;
                8'h3D:                      w_cls = C_EQ;
                8'h20:                      w_cls = (ALLOW_SPACE != 0) ? C_SPACE : C_ILL;
                default:                    w_cls = C_ILL;
            endcase
        end
    end

    // A byte after '=' starts a fresh expression: behave as S_EXP with cleared counters.
    always_comb begin
        w_eff_state  = (r_state == S_DONE) ? S_EXP : r_state;
        w_base_depth = (r_state == S_DONE) ? 4'd0 : r_depth;
        w_base_op    = (r_state == S_DONE) ? '0 : r_op_cnt;
        w_base_dig   = (r_state == S_DONE) ? 4'd0 : r_dig_cnt;
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_depth_nxt   = r_depth;
        w_op_cnt_nxt  = r_op_cnt;
        w_dig_cnt_nxt = r_dig_cnt;
        w_done_nxt    = 1'b0;
        w_fail        = 1'b0;

        if (in_valid && r_state != S_ERR) begin
            w_state_nxt   = w_eff_state;
            w_depth_nxt   = w_base_depth;
            w_op_cnt_nxt  = w_base_op;
            w_dig_cnt_nxt = w_base_dig;

            case (w_eff_state)
                S_EXP: begin
                    case (w_cls)
                        C_DIGIT: begin
                            w_state_nxt   = S_NUM;
                            w_dig_cnt_nxt = 4'd1;
                        end
                        C_OPEN: begin
                            if (w_base_depth < LP_MAX_DEPTH) begin
                                w_depth_nxt = w_base_depth + 4'd1;
                            end else begin
                                w_fail = 1'b1;
                            end
                        end
                        C_SPACE: w_state_nxt = S_EXP;
                        default: w_fail = 1'b1;
                    endcase
                end
                S_NUM, S_CLOSE: begin
                    case (w_cls)
                        C_DIGIT: begin
                            if (w_eff_state == S_NUM && w_base_dig < LP_MAX_DIG) begin
                                w_dig_cnt_nxt = w_base_dig + 4'd1;
                            end else begin
                                w_fail = 1'b1;
                            end
                        end
                        C_OP: begin
                            w_state_nxt = S_EXP;
                            if (w_base_op != LP_OP_MAX) begin
                                w_op_cnt_nxt = w_base_op + 1'b1;
                            end
                        end
                        C_CLOSE: begin
                            if (w_base_depth != 4'd0) begin
                                w_depth_nxt = w_base_depth - 4'd1;
                                w_state_nxt = S_CLOSE;
                            end else begin
                                w_fail = 1'b1;
                            end
                        end
                        C_EQ: begin
                            if (w_base_depth == 4'd0) begin
                                w_state_nxt = S_DONE;
                                w_done_nxt  = 1'b1;
                            end else begin
                                w_fail = 1'b1;
                            end
                        end
                        C_SPACE: w_state_nxt = S_CLOSE;
                        default: w_fail = 1'b1;
                    endcase
                end
                default: w_fail = 1'b1;
            endcase

            // The offending byte must not disturb the visible counters.
            if (w_fail) begin
                w_state_nxt   = S_ERR;
                w_depth_nxt   = r_depth;
                w_op_cnt_nxt  = r_op_cnt;
                w_dig_cnt_nxt = r_dig_cnt;
                w_done_nxt    = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_state   <= S_EXP;
            r_depth   <= 4'd0;
            r_op_cnt  <= '0;
            r_dig_cnt <= 4'd0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_depth   <= w_depth_nxt;
            r_op_cnt  <= w_op_cnt_nxt;
            r_dig_cnt <= w_dig_cnt_nxt;
            r_done    <= w_done_nxt;
        end
    end

    assign out    = (((r_state == S_NUM) || (r_state == S_CLOSE)) && (r_depth == 4'd0))
                    || (r_state == S_DONE);
    assign err    = (r_state == S_ERR);
    assign done   = r_done;
    assign state  = r_state;
    assign depth  = r_depth;
    assign op_cnt = r_op_cnt;

endmodule

// File: tb/tb_expr_scanner.sv
// Directed-vector bench for expr_scanner; a second instance covers ALLOW_SPACE=0 and a narrow saturating op counter.
`timescale 1ns/1ps
module tb_expr_scanner;

    logic       clk;
    logic       clr;
    logic       in_valid;
    logic [7:0] in;

    logic       out_a, err_a, done_a;
    logic [2:0] state_a;
    logic [3:0] depth_a;
    logic [7:0] op_a;

    logic       out_b, err_b, done_b;
    logic [2:0] state_b;
    logic [3:0] depth_b;
    logic [1:0] op_b;

    int n_vec;
    int n_miscmp;

    expr_scanner u_dut (
        .clk      (clk),
        .clr      (clr),
        .in_valid (in_valid),
        .in       (in),
        .out      (out_a),
        .err      (err_a),
        .done     (done_a),
        .state    (state_a),
        .depth    (depth_a),
        .op_cnt   (op_a)
    );

    expr_scanner #(.ALLOW_SPACE(0), .CNT_W(2)) u_nosp (
        .clk      (clk),
        .clr      (clr),
        .in_valid (in_valid),
        .in       (in),
        .out      (out_b),
        .err      (err_b),
        .done     (done_b),
        .state    (state_b),
        .depth    (depth_b),
        .op_cnt   (op_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_miscmp++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic send(input byte b);
        @(negedge clk);
        in       = b;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send(s[i]);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        clr = 1'b0;
        #2;
        clr = 1'b1;
    endtask

    task automatic check_a(input string tag, input int st, input int o, input int e,
                           input int dp, input int oc);
        check({tag, ".state"}, state_a, st);
        check({tag, ".out"},   out_a,   o);
        check({tag, ".err"},   err_a,   e);
        check({tag, ".depth"}, depth_a, dp);
        check({tag, ".op"},    op_a,    oc);
    endtask

    initial begin
        n_vec    = 0;
        n_miscmp = 0;
        clr      = 1'b0;
        in_valid = 1'b0;
        in       = 8'h00;
        #12;
        check_a("rst", 0, 0, 0, 0, 0);
        check("rst.done", done_a, 0);
        check("rst_b.state", state_b, 0);
        clr = 1'b1;

        // Flat expression, out toggles per operand/operator
        do_reset();
        send("1"); check("t1.out1", out_a, 1);
        send("*"); check("t1.out2", out_a, 0);
        send("2"); check("t1.out3", out_a, 1);
        send("+"); check("t1.out4", out_a, 0);
        send("3"); check_a("t1.end", 1, 1, 0, 0, 2);

        // Parenthesised expression with '=' and restart
        do_reset();
        send("("); check_a("t2.open", 0, 0, 0, 1, 0);
        send_str("12+3");
        check_a("t2.in", 1, 0, 0, 1, 1);
        send(")"); check_a("t2.close", 2, 1, 0, 0, 1);
        send_str("*4");
        send("=");
        check_a("t2.eq", 3, 1, 0, 0, 2);
        check("t2.done1", done_a, 1);
        idle(1);
        check("t2.done0", done_a, 0);
        check("t2.hold", state_a, 3);
        send("7"); check_a("t2.restart", 1, 1, 0, 0, 0);
        check("t2.done_after", done_a, 0);

        // Digit overflow and absorbing error
        do_reset();
        send_str("1234"); check("t3.four", state_a, 1);
        send("5"); check_a("t3.five", 4, 0, 1, 0, 0);
        send_str("+(1"); idle(2);
        check_a("t3.absorb", 4, 0, 1, 0, 0);

        // Nesting limits
        do_reset();
        send_str("((("); check("t4.d3", depth_a, 3);
        send("("); check_a("t4.d4", 4, 0, 1, 3, 0);
        do_reset();
        send(")"); check("t4.under", err_a, 1);
        do_reset();
        send_str("(1="); check_a("t4.eq_open", 4, 0, 1, 1, 0);

        // Spaces
        do_reset();
        send("1"); send(" ");
        check("t5.sp_a", state_a, 2);
        check("t5.sp_b_err", err_b, 1);
        send_str("+ 2"); check_a("t5.sp_ok", 1, 1, 0, 0, 1);
        do_reset();
        send_str("1 "); check("t5.gap", err_a, 0);
        send("2"); check("t5.12", err_a, 1);
        do_reset();
        send("a"); check("t5.illegal", err_a, 1);

        // op counter saturation on the 2-bit instance
        do_reset();
        send_str("1+1+1+1+1");
        check("t6.op_a", op_a, 4);
        check("t6.op_b", op_b, 3);
        check("t6.state_b", state_b, 1);

        // in_valid gaps and async clear mid-stream
        do_reset();
        send("1"); idle(3); check_a("t7.gap1", 1, 1, 0, 0, 0);
        send("+"); idle(2); check_a("t7.gap2", 0, 0, 0, 0, 1);
        send("(");
        @(negedge clk);
        clr = 1'b0;
        #1;
        check_a("t7.clr", 0, 0, 0, 0, 0);
        #1;
        clr = 1'b1;
        send("5"); check("t7.after", out_a, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running, expected finished");
        $fatal(1, "timeout");
    end

endmodule
